// File: rtl/noisy_sig_gen.sv
// rtl/noisy_sig_gen.sv - periodic triangle/square source with additive LFSR noise
module noisy_sig_gen #(
    parameter int          N     = 16,
    parameter int          DIV_W = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wave_sel,
    input  logic [N-1:0]     amp,
    input  logic [N-1:0]     step,
    input  logic [DIV_W-1:0] hold,
    input  logic [DIV_W-1:0] rate_div,
    input  logic [3:0]       noise_bits,
    output logic [N-1:0]     clean,
    output logic [N-1:0]     noisy,
    output logic             sample_valid
);

    typedef enum logic [2:0] {IDLE, UP, DOWN, HIGH, LOW} state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] hold_cnt;
    logic [DIV_W-1:0] hold_r;
    logic [DIV_W-1:0] hold_eff;
    logic [N-1:0]     amp_r;
    logic [N-1:0]     step_r;
    logic [N-1:0]     s;
    logic [N-1:0]     s_next;
    logic [N-1:0]     n;
    logic [N-1:0]     noisy_next;
    logic [N:0]       up_sum;
    logic [N:0]       noisy_sum;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [15:0]      noise_mask;
    logic             tick;
    logic             hold_done;

    always_comb begin
        tick       = (state != IDLE) && enable && (div_cnt == rate_div);
        hold_eff   = (hold_r == '0) ? DIV_W'(1) : hold_r;
        hold_done  = (hold_cnt == hold_eff - DIV_W'(1));
        up_sum     = {1'b0, s} + {1'b0, step_r};
        s_next     = s;
        state_next = state;
        case (state)
            UP: begin
                if (up_sum > {1'b0, amp_r}) begin
                    s_next     = amp_r;
                    state_next = DOWN;
                end else begin
                    s_next = up_sum[N-1:0];
                end
            end
            DOWN: begin
                if (step_r > s) begin
                    s_next     = '0;
                    state_next = UP;
                end else begin
                    s_next = s - step_r;
                end
            end
            HIGH: begin
                // the switching tick still emits this state's level
                s_next = amp_r;
                if (hold_done) state_next = LOW;
            end
            LOW: begin
                s_next = '0;
                if (hold_done) state_next = HIGH;
            end
            default: begin
                s_next     = s;
                state_next = state;
            end
        endcase
        noise_mask = 16'((17'd1 << noise_bits) - 17'd1);
        n          = N'(lfsr & noise_mask);
        noisy_sum  = {1'b0, s_next} + {1'b0, n};
        noisy_next = noisy_sum[N] ? '1 : noisy_sum[N-1:0];
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            hold_cnt     <= '0;
            hold_r       <= '0;
            amp_r        <= '0;
            step_r       <= '0;
            s            <= '0;
            lfsr         <= SEED;
            clean        <= '0;
            noisy        <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == IDLE) begin
                if (enable) begin
                    amp_r    <= amp;
                    step_r   <= step;
                    hold_r   <= hold;
                    div_cnt  <= '0;
                    hold_cnt <= '0;
                    s        <= '0;
                    state    <= wave_sel ? UP : HIGH;
                end
            end else if (!enable) begin
                state <= IDLE;
            end else if (tick) begin
                div_cnt      <= '0;
                s            <= s_next;
                state        <= state_next;
                hold_cnt     <= hold_done ? '0 : hold_cnt + DIV_W'(1);
                lfsr         <= lfsr_next;
                clean        <= s_next;
                noisy        <= noisy_next;
                sample_valid <= 1'b1;
            end else begin
                // wraps through 2^DIV_W if rate_div drops below div_cnt
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_noisy_sig_gen.sv
// tb/tb_noisy_sig_gen.sv - randomized self-checking bench for noisy_sig_gen
module tb_noisy_sig_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wave_sel;
    logic [15:0] amp;
    logic [15:0] step;
    logic [15:0] hold;
    logic [15:0] rate_div;
    logic [3:0]  noise_bits;
    logic [15:0] clean;
    logic [15:0] noisy;
    logic        sample_valid;

    noisy_sig_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .wave_sel(wave_sel),
        .amp(amp), .step(step), .hold(hold), .rate_div(rate_div),
        .noise_bits(noise_bits), .clean(clean), .noisy(noisy),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    int m_clean, m_noisy, m_s, m_k, m_wave, m_amp, m_step, m_hold, m_rd, cyc;
    bit m_up;
    int got_clean[$];
    int got_noisy[$];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_clean = 0;
        m_noisy = 0;
    endtask

    task automatic model_tick(input int nb);
        int s_new, nz, he;
        if (m_wave != 0) begin
            if (m_up) begin
                if (m_s + m_step > m_amp) begin s_new = m_amp; m_up = 1'b0; end
                else s_new = m_s + m_step;
            end else begin
                if (m_step > m_s) begin s_new = 0; m_up = 1'b1; end
                else s_new = m_s - m_step;
            end
        end else begin
            he    = (m_hold == 0) ? 1 : m_hold;
            s_new = (((m_k / he) % 2) == 0) ? m_amp : 0;
            m_k++;
        end
        m_s     = s_new;
        nz      = int'(m_lfsr) & ((1 << nb) - 1);
        m_clean = s_new;
        m_noisy = (s_new + nz > 65535) ? 65535 : s_new + nz;
        m_lfsr  = lfsr_adv(m_lfsr);
        got_clean.push_back(m_clean);
        got_noisy.push_back(m_noisy);
    endtask

    task automatic check_outputs(input string tag, input bit exp_valid);
        expect_eq({tag, "_valid"}, sample_valid, exp_valid);
        expect_eq({tag, "_clean"}, clean, m_clean);
        expect_eq({tag, "_noisy"}, noisy, m_noisy);
    endtask

    task automatic start_run(input int ws, input int a, input int st, input int h, input int rd, input int nb);
        wave_sel = ws[0]; amp = a[15:0]; step = st[15:0]; hold = h[15:0];
        rate_div = rd[15:0]; noise_bits = nb[3:0]; enable = 1'b1;
        m_wave = ws; m_amp = a; m_step = st; m_hold = h; m_rd = rd;
        m_s = 0; m_up = 1'b1; m_k = 0; cyc = 0;
        got_clean.delete();
        got_noisy.delete();
        @(posedge clk);
        @(negedge clk);
        check_outputs("start", 1'b0);
    endtask

    task automatic run_cycles(input int k, input bit rnd);
        bit tk;
        for (int i = 0; i < k; i++) begin
            if (rnd) begin
                noise_bits = 4'($urandom_range(0, 15));
                amp        = 16'($urandom);
                step       = 16'($urandom);
                hold       = 16'($urandom);
                wave_sel   = 1'($urandom);
            end
            @(posedge clk);
            cyc++;
            tk = ((cyc % (m_rd + 1)) == 0);
            if (tk) model_tick(int'(noise_bits));
            @(negedge clk);
            check_outputs("run", tk);
        end
    endtask

    task automatic idle_cycles(input int k);
        enable = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs("idle", 1'b0);
        end
    endtask

    task automatic check_queue(input string tag, input int exp[], input bit use_noisy);
        expect_eq({tag, "_count"}, got_clean.size() >= exp.size(), 1);
        for (int i = 0; i < exp.size() && i < got_clean.size(); i++)
            expect_eq(tag, use_noisy ? got_noisy[i] : got_clean[i], exp[i]);
    endtask

    initial begin
        int tri_exp[] = '{30, 60, 90, 100, 70, 40, 10, 0, 30};
        int sq_exp[]  = '{500, 500, 0, 0, 500};
        int nz_exp[]  = '{1001, 1003, 1007};
        reset = 1'b1; enable = 1'b0; wave_sel = 1'b0; amp = '0; step = '0;
        hold = '0; rate_div = '0; noise_bits = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 1'b0);
        reset = 1'b0;
        idle_cycles(2);

        start_run(0, 1000, 0, 8, 0, 4);
        run_cycles(3, 1'b0);
        check_queue("noise_seq", nz_exp, 1'b1);
        idle_cycles(2);

        start_run(0, 500, 0, 2, 3, 0);
        run_cycles(20, 1'b0);
        check_queue("square_seq", sq_exp, 1'b0);
        idle_cycles(2);

        start_run(1, 100, 30, 0, 0, 0);
        run_cycles(9, 1'b0);
        check_queue("tri_seq", tri_exp, 1'b0);
        check_queue("tri_noisy", tri_exp, 1'b1);
        idle_cycles(2);

        start_run(0, 65535, 0, 3, 0, 4);
        run_cycles(1, 1'b0);
        expect_eq("sat_noisy", noisy, 16'hFFFF);
        expect_eq("sat_clean", clean, 16'hFFFF);
        idle_cycles(2);

        start_run(1, 100, 30, 0, 0, 3);
        run_cycles(5, 1'b0);
        idle_cycles(5);
        start_run(1, 100, 30, 0, 0, 3);
        run_cycles(2, 1'b0);
        expect_eq("resume_clean", got_clean[0], 30);
        idle_cycles(2);

        for (int r = 0; r < 25; r++) begin
            int a, st;
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65000, 65535)) : int'($urandom_range(0, 5000));
            st = int'($urandom_range(0, 1500));
            start_run(int'($urandom_range(0, 1)), a, st, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            run_cycles(int'($urandom_range(8, 40)), 1'b1);
            idle_cycles(int'($urandom_range(1, 3)));
        end

        start_run(1, 100, 30, 0, 0, 5);
        run_cycles(6, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        expect_eq("async_rst_clean", clean, 0);
        expect_eq("async_rst_noisy", noisy, 0);
        expect_eq("async_rst_valid", sample_valid, 0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(1);
        start_run(0, 1000, 0, 8, 0, 4);
        run_cycles(3, 1'b0);
        check_queue("post_rst_noise", nz_exp, 1'b1);
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
